// File: rtl/deb_pkg.sv
// Shared definitions for the multi-channel button debouncer: FSM state encodings
// and the counter width helper.
package deb_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_UP         = 3'd0;
   localparam logic [STATE_W-1:0] ST_TRANS_DOWN = 3'd1;
   localparam logic [STATE_W-1:0] ST_HOLD_DOWN  = 3'd2;
   localparam logic [STATE_W-1:0] ST_DOWN       = 3'd3;
   localparam logic [STATE_W-1:0] ST_TRANS_UP   = 3'd4;
   localparam logic [STATE_W-1:0] ST_HOLD_UP    = 3'd5;

   // Bits needed to hold the values 0..max_val inclusive
   function automatic int unsigned cnt_w(input int unsigned max_val);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) <= 64'(max_val)) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/deb_chan.sv
// One debounce channel: polarity fix, 2-flop synchroniser, debounce FSM and the
// press-age / auto-repeat counters that produce the long and rpt strobes.
module deb_chan
   import deb_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = 32'd2000000,
   parameter int unsigned LONG_CYCLES   = 32'd12000000,
   parameter int unsigned REPEAT_CYCLES = 32'd3000000,
   parameter bit          REPEAT_EN     = 1'b1,
   parameter bit          ACTIVE_LOW    = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_down,
   output logic o_up,
   output logic o_is_down,
   output logic o_is_up,
   output logic o_long,
   output logic o_rpt
);

   localparam int unsigned HW = cnt_w(HOLD_CYCLES);
   localparam int unsigned AW = cnt_w(LONG_CYCLES);
   localparam int unsigned RW = cnt_w(REPEAT_CYCLES);

   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [AW-1:0] AGE_LONG  = AW'(LONG_CYCLES);
   localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_CYCLES);

   logic [1:0]         r_sync;
   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next;
   logic [HW-1:0]      r_hold_cnt;
   logic [AW-1:0]      r_age;
   logic [RW-1:0]      r_rpt_cnt;
   logic               r_long_seen;
   logic               w_pressed;
   logic               w_hold_done;
   logic               w_is_down;
   logic               w_long;
   logic               w_rpt;

   // Normalise polarity so 1 means pressed, then synchronise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= 2'b00;
      else        r_sync <= {r_sync[0], i_btn ^ ACTIVE_LOW};
   end

   assign w_pressed   = r_sync[1];
   assign w_hold_done = (r_hold_cnt == HOLD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_UP;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_UP:         if (w_pressed) w_next = ST_TRANS_DOWN;
         ST_TRANS_DOWN: w_next = ST_HOLD_DOWN;
         ST_HOLD_DOWN:  if (w_hold_done) w_next = ST_DOWN;
         ST_DOWN:       if (!w_pressed) w_next = ST_TRANS_UP;
         ST_TRANS_UP:   w_next = ST_HOLD_UP;
         ST_HOLD_UP:    if (w_hold_done) w_next = ST_UP;
         default:       w_next = ST_UP;
      endcase
   end

   always_comb begin
      o_down    = 1'b0;
      o_up      = 1'b0;
      w_is_down = 1'b0;
      case (r_state)
         ST_TRANS_DOWN: begin
            o_down    = 1'b1;
            w_is_down = 1'b1;
         end
         ST_HOLD_DOWN, ST_DOWN: w_is_down = 1'b1;
         ST_TRANS_UP:           o_up = 1'b1;
         default: ;
      endcase
   end

   // Lockout counter: cleared on entry to a hold window, runs HOLD_CYCLES inside it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_cnt <= '0;
      end else if (r_state == ST_TRANS_DOWN || r_state == ST_TRANS_UP) begin
         r_hold_cnt <= '0;
      end else if ((r_state == ST_HOLD_DOWN || r_state == ST_HOLD_UP) && !w_hold_done) begin
         r_hold_cnt <= r_hold_cnt + HW'(1);
      end
   end

   assign w_long = w_is_down && !r_long_seen && (r_age == AGE_LONG);
   assign w_rpt  = REPEAT_EN && w_is_down && r_long_seen && (r_rpt_cnt == RPT_LAST);

   // Age is 0 during TRANS_DOWN; repeat phase starts the cycle after long
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_age       <= '0;
         r_rpt_cnt   <= '0;
         r_long_seen <= 1'b0;
      end else if (w_next == ST_TRANS_DOWN) begin
         r_age       <= '0;
         r_rpt_cnt   <= '0;
         r_long_seen <= 1'b0;
      end else if (w_is_down) begin
         if (r_age != AGE_LONG) r_age <= r_age + AW'(1);
         if (w_long) begin
            r_long_seen <= 1'b1;
            r_rpt_cnt   <= RW'(1);
         end else if (r_long_seen) begin
            r_rpt_cnt <= (r_rpt_cnt == RPT_LAST) ? RW'(1) : r_rpt_cnt + RW'(1);
         end
      end
   end

   assign o_is_down = w_is_down;
   assign o_is_up   = ~w_is_down;
   assign o_long    = w_long;
   assign o_rpt     = w_rpt;

endmodule

// File: rtl/deb_array.sv
// Multi-channel button debouncer for the sequencer front panel: one independent
// deb_chan per button pin.
module deb_array
   import deb_pkg::*;
#(
   parameter int unsigned N             = 4,
   parameter int unsigned HOLD_CYCLES   = 32'd2000000,
   parameter int unsigned LONG_CYCLES   = 32'd12000000,
   parameter int unsigned REPEAT_CYCLES = 32'd3000000,
   parameter bit          REPEAT_EN     = 1'b1,
   parameter bit          ACTIVE_LOW    = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] btn,
   output logic [N-1:0] down,
   output logic [N-1:0] up,
   output logic [N-1:0] is_down,
   output logic [N-1:0] is_up,
   output logic [N-1:0] long,
   output logic [N-1:0] rpt
);

   localparam int unsigned CHK_STATE_W = STATE_W;

   if (N < 1) begin : g_bad_n
      $error("deb_array: N must be at least 1");
   end
   if (HOLD_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1 || CHK_STATE_W != 3) begin : g_bad_cycles
      $error("deb_array: cycle parameters must be at least 1");
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_chan
      deb_chan #(
         .HOLD_CYCLES   (HOLD_CYCLES),
         .LONG_CYCLES   (LONG_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES),
         .REPEAT_EN     (REPEAT_EN),
         .ACTIVE_LOW    (ACTIVE_LOW)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_btn     (btn[gi]),
         .o_down    (down[gi]),
         .o_up      (up[gi]),
         .o_is_down (is_down[gi]),
         .o_is_up   (is_up[gi]),
         .o_long    (long[gi]),
         .o_rpt     (rpt[gi])
      );
   end

endmodule

// File: tb/tb_deb_array.sv
// Directed bench for deb_array: dut_a is active-high with repeat on, dut_b is
// active-low with repeat off. Events are logged per cycle and checked per scenario.
module tb_deb_array;

   logic       clk = 1'b0;
   logic       rst_n_a, rst_n_b;
   logic [1:0] btn_a, btn_b;
   logic [1:0] down_a, up_a, is_down_a, is_up_a, long_a, rpt_a;
   logic [1:0] down_b, up_b, is_down_b, is_up_b, long_b, rpt_b;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int n_down[2], n_up[2], n_long[2], n_rpt[2], n_isd[2];
   int t_down[2], t_up[2], t_long[2];
   int q_rpt1[$];
   int n_bad_inv;
   int nb_up, nb_long0, nb_rpt, nb_ch1, nb_down0;

   always #5 clk = ~clk;

   deb_array #(.N(2), .HOLD_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8),
               .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .btn(btn_a), .down(down_a), .up(up_a),
      .is_down(is_down_a), .is_up(is_up_a), .long(long_a), .rpt(rpt_a));

   deb_array #(.N(2), .HOLD_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8),
               .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .btn(btn_b), .down(down_b), .up(up_b),
      .is_down(is_down_b), .is_up(is_up_b), .long(long_b), .rpt(rpt_b));

   always @(posedge clk) cyc <= cyc + 1;

   // Event log, sampled mid-cycle
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (down_a[i])    begin n_down[i]++; t_down[i] = cyc; end
         if (up_a[i])      begin n_up[i]++;   t_up[i]   = cyc; end
         if (long_a[i])    begin n_long[i]++; t_long[i] = cyc; end
         if (rpt_a[i])     begin n_rpt[i]++;  if (i == 1) q_rpt1.push_back(cyc); end
         if (is_down_a[i]) n_isd[i]++;
         if (is_up_a[i] !== ~is_down_a[i]) n_bad_inv++;
         if (is_up_b[i] !== ~is_down_b[i]) n_bad_inv++;
      end
      if (up_b != 2'b00)  nb_up++;
      if (rpt_b != 2'b00) nb_rpt++;
      if (long_b[0])      nb_long0++;
      if (down_b[0])      nb_down0++;
      if (down_b[1] || up_b[1] || long_b[1] || is_down_b[1]) nb_ch1++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      for (int i = 0; i < 2; i++) begin
         n_down[i] = 0; n_up[i] = 0; n_long[i] = 0; n_rpt[i] = 0; n_isd[i] = 0;
         t_down[i] = -1; t_up[i] = -1; t_long[i] = -1;
      end
      q_rpt1.delete();
      nb_up = 0; nb_rpt = 0; nb_long0 = 0; nb_ch1 = 0; nb_down0 = 0;
   endtask

   task automatic test_reset();
      int c0;
      rst_n_a = 1'b0; rst_n_b = 1'b0;
      btn_a = 2'b11; btn_b = 2'b11;
      tick(3);
      @(negedge clk);
      n_tests++;
      if (is_up_a !== 2'b11) begin n_fail++; $display("FAIL reset_is_up: got %b expected 11", is_up_a); end
      n_tests++;
      if ({down_a, up_a, is_down_a, long_a, rpt_a} !== 10'b0) begin
         n_fail++; $display("FAIL reset_outputs: got %b expected 0", {down_a, up_a, is_down_a, long_a, rpt_a});
      end
      tick(1);
      clear_log();
      c0 = cyc + 1;
      rst_n_a = 1'b1; rst_n_b = 1'b1;
      tick(8);
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if (n_down[i] != 1 || t_down[i] != c0 + 2) begin
            n_fail++; $display("FAIL reset_release_down%0d: got count %0d at %0d expected 1 at %0d", i, n_down[i], t_down[i], c0 + 2);
         end
      end
      btn_a = 2'b00;
      tick(20);
   endtask

   task automatic test_bounce();
      int c0;
      bit held;
      clear_log();
      c0 = cyc + 1;
      btn_a[0] = 1'b1; tick(1);
      btn_a[0] = 1'b0; tick(1);
      btn_a[0] = 1'b1; tick(1);
      btn_a[0] = 1'b0; tick(1);
      btn_a[0] = 1'b1;
      held = 1'b1;
      // is_down must stay high from the down strobe through cycle c0+16
      while (cyc < c0 + 16) begin
         @(negedge clk);
         if (cyc >= c0 + 2 && !is_down_a[0]) held = 1'b0;
      end
      n_tests++;
      if (n_down[0] != 1 || t_down[0] != c0 + 2) begin
         n_fail++; $display("FAIL bounce_down: got count %0d at %0d expected 1 at %0d", n_down[0], t_down[0], c0 + 2);
      end
      n_tests++;
      if (n_up[0] != 0) begin n_fail++; $display("FAIL bounce_no_up: got %0d expected 0", n_up[0]); end
      n_tests++;
      if (!held) begin n_fail++; $display("FAIL bounce_is_down_held: got dropout expected steady high"); end
      tick(1);
      btn_a[0] = 1'b0;
      tick(20);
   endtask

   task automatic test_long_repeat();
      int c0, c;
      clear_log();
      c0 = cyc + 1;
      c  = c0 + 2;
      btn_a[1] = 1'b1;
      tick(60);
      btn_a[1] = 1'b0;
      tick(20);
      n_tests++;
      if (n_down[1] != 1 || t_down[1] != c) begin
         n_fail++; $display("FAIL long_down: got count %0d at %0d expected 1 at %0d", n_down[1], t_down[1], c);
      end
      n_tests++;
      if (n_long[1] != 1 || t_long[1] != c + 20) begin
         n_fail++; $display("FAIL long_strobe: got count %0d at %0d expected 1 at %0d", n_long[1], t_long[1], c + 20);
      end
      n_tests++;
      if (q_rpt1.size() != 4) begin
         n_fail++; $display("FAIL rpt_count: got %0d expected 4", q_rpt1.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (q_rpt1[k] != c + 28 + 8 * k) begin
               n_fail++; $display("FAIL rpt_time%0d: got %0d expected %0d", k, q_rpt1[k], c + 28 + 8 * k);
            end
         end
      end
      n_tests++;
      if (n_up[1] != 1 || t_up[1] != c0 + 62) begin
         n_fail++; $display("FAIL long_up: got count %0d at %0d expected 1 at %0d", n_up[1], t_up[1], c0 + 62);
      end
      n_tests++;
      if (n_down[0] + n_up[0] + n_long[0] + n_rpt[0] != 0) begin
         n_fail++; $display("FAIL long_ch0_quiet: got %0d events expected 0", n_down[0] + n_up[0] + n_long[0] + n_rpt[0]);
      end
   endtask

   task automatic test_glitch();
      int c0;
      clear_log();
      c0 = cyc + 1;
      btn_a[0] = 1'b1; tick(1);
      btn_a[0] = 1'b0;
      tick(40);
      n_tests++;
      if (n_isd[0] != 6) begin n_fail++; $display("FAIL glitch_width: got %0d cycles expected 6", n_isd[0]); end
      n_tests++;
      if (n_up[0] != 1 || t_up[0] != c0 + 8) begin
         n_fail++; $display("FAIL glitch_up: got count %0d at %0d expected 1 at %0d", n_up[0], t_up[0], c0 + 8);
      end
      n_tests++;
      if (n_long[0] != 0) begin n_fail++; $display("FAIL glitch_no_long: got %0d expected 0", n_long[0]); end
   endtask

   task automatic test_polarity_reset();
      int c0;
      clear_log();
      c0 = cyc + 1;
      btn_b = 2'b10;
      tick(32);
      n_tests++;
      if (nb_down0 != 1) begin n_fail++; $display("FAIL pol_down: got %0d expected 1", nb_down0); end
      n_tests++;
      if (nb_long0 != 1) begin n_fail++; $display("FAIL pol_long: got %0d expected 1", nb_long0); end
      n_tests++;
      if (nb_rpt != 0) begin n_fail++; $display("FAIL pol_rpt_disabled: got %0d expected 0", nb_rpt); end
      n_tests++;
      if (nb_ch1 != 0) begin n_fail++; $display("FAIL pol_ch1_idle: got %0d events expected 0", nb_ch1); end
      n_tests++;
      if (is_down_b !== 2'b01) begin n_fail++; $display("FAIL pol_is_down: got %b expected 01", is_down_b); end
      rst_n_b = 1'b0;
      #1;
      n_tests++;
      if (is_up_b !== 2'b11 || {down_b, up_b, long_b, rpt_b} !== 8'b0) begin
         n_fail++; $display("FAIL midhold_reset: got is_up %b strobes %b expected 11 and 0", is_up_b, {down_b, up_b, long_b, rpt_b});
      end
      tick(3);
      btn_b = 2'b11;
      tick(2);
      rst_n_b = 1'b1;
      tick(20);
      n_tests++;
      if (nb_up != 0) begin n_fail++; $display("FAIL midhold_no_up: got %0d expected 0", nb_up); end
      n_tests++;
      if (n_bad_inv != 0) begin n_fail++; $display("FAIL is_up_inverse: got %0d bad cycles expected 0", n_bad_inv); end
   endtask

   initial begin
      n_bad_inv = 0;
      clear_log();
      test_reset();
      test_bounce();
      test_long_repeat();
      test_glitch();
      test_polarity_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
